mem_addr_sequencer: RTL and testbench



---
 rtl/mem_addr_sequencer.sv | 158 +++++++++++++++
 tb/tb_mem_addr_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_sequencer.sv
// mem_addr_sequencer: registered memory-address source for the multicycle
// datapath, with an exception vector fetch that takes over the memory port.
//
// Normal mode (IDLE): addr_o follows src[sel_i] one edge later (0 when
// sel_i >= N_SRC). A valid exception request presents VEC_BASE+code on
// addr_o, pulses mem_rd_o for one cycle, waits MEM_LAT edges and captures
// mem_data_i[7:0] (zero-extended) into vec_target_o with a vec_valid_o pulse.
// Requests arriving while busy, or carrying an out-of-range code, are
// rejected with a one-cycle exc_drop_o pulse.
//
// Ports:
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset
//   src_bus_i     N_SRC packed address sources, src[i] = [i*DATA_W +: DATA_W]
//   sel_i         normal-mode source select
//   exc_req_i     exception request
//   exc_code_i    exception code, valid with exc_req_i
//   mem_data_i    memory read data (only [7:0] used)
//   addr_o        registered memory address
//   mem_rd_o      one-cycle read strobe for the vector fetch
//   busy_o        exception sequence in progress
//   vec_target_o  captured vector byte, zero-extended
//   vec_valid_o   one-cycle pulse when vec_target_o updates
//   exc_drop_o    one-cycle pulse per rejected request
module mem_addr_sequencer #(
  parameter int DATA_W   = 32,
  parameter int N_SRC    = 4,
  parameter int N_EXC    = 3,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 1,
  localparam int SEL_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int CODE_W  = (N_EXC > 1) ? $clog2(N_EXC) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_SRC*DATA_W-1:0] src_bus_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    exc_req_i,
  input  logic [CODE_W-1:0]       exc_code_i,
  input  logic [DATA_W-1:0]       mem_data_i,
  output logic [DATA_W-1:0]       addr_o,
  output logic                    mem_rd_o,
  output logic                    busy_o,
  output logic [DATA_W-1:0]       vec_target_o,
  output logic                    vec_valid_o,
  output logic                    exc_drop_o
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   vec_target_q, vec_target_d;
  logic                vec_valid_q, vec_valid_d;
  logic                exc_drop_q, exc_drop_d;

  // Unpack the flat source bus into an indexable array.
  logic [DATA_W-1:0] src_arr [N_SRC];
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src_arr[i] = src_bus_i[i*DATA_W +: DATA_W];
  end

  logic              sel_ok, code_ok;
  logic [DATA_W-1:0] src_addr, vec_addr;

  assign sel_ok   = 32'(sel_i) < N_SRC;
  assign code_ok  = 32'(exc_code_i) < N_EXC;
  assign src_addr = sel_ok ? src_arr[sel_i] : '0;
  // Sum is taken in DATA_W bits so it wraps rather than widening.
  assign vec_addr = DATA_W'(VEC_BASE) + DATA_W'(exc_code_i);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    mem_rd_d     = 1'b0;
    busy_d       = busy_q;
    vec_target_d = vec_target_q;
    vec_valid_d  = 1'b0;
    exc_drop_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        addr_d = src_addr;
        if (exc_req_i) begin
          if (code_ok) begin
            // Exception takes the port ahead of the normal source update.
            addr_d   = vec_addr;
            mem_rd_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = FETCH;
          end else begin
            exc_drop_d = 1'b1;
          end
        end
      end
      FETCH: begin
        exc_drop_d = exc_req_i;
        cnt_d      = CNT_W'(MEM_LAT - 1);
        state_d    = WAIT;
      end
      WAIT: begin
        exc_drop_d = exc_req_i;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          vec_target_d = {{(DATA_W-8){1'b0}}, mem_data_i[7:0]};
          vec_valid_d  = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      mem_rd_q     <= 1'b0;
      busy_q       <= 1'b0;
      vec_target_q <= '0;
      vec_valid_q  <= 1'b0;
      exc_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      mem_rd_q     <= mem_rd_d;
      busy_q       <= busy_d;
      vec_target_q <= vec_target_d;
      vec_valid_q  <= vec_valid_d;
      exc_drop_q   <= exc_drop_d;
    end
  end

  assign addr_o       = addr_q;
  assign mem_rd_o     = mem_rd_q;
  assign busy_o       = busy_q;
  assign vec_target_o = vec_target_q;
  assign vec_valid_o  = vec_valid_q;
  assign exc_drop_o   = exc_drop_q;

endmodule

// File: tb/tb_mem_addr_sequencer.sv
module tb_mem_addr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [127:0] src_bus;
  logic [1:0]  sel;
  logic        exc_req;
  logic [1:0]  exc_code;
  logic [31:0] mem_data;

  // MEM_LAT = 1 instance
  logic [31:0] a1, vt1;
  logic        rd1, bz1, vv1, dr1;
  // MEM_LAT = 3 instance
  logic [31:0] a3, vt3;
  logic        rd3, bz3, vv3, dr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_addr_sequencer #(.DATA_W(32), .N_SRC(4), .N_EXC(3), .VEC_BASE(253), .MEM_LAT(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .src_bus_i(src_bus), .sel_i(sel),
    .exc_req_i(exc_req), .exc_code_i(exc_code), .mem_data_i(mem_data),
    .addr_o(a1), .mem_rd_o(rd1), .busy_o(bz1), .vec_target_o(vt1),
    .vec_valid_o(vv1), .exc_drop_o(dr1));

  mem_addr_sequencer #(.DATA_W(32), .N_SRC(4), .N_EXC(3), .VEC_BASE(253), .MEM_LAT(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .src_bus_i(src_bus), .sel_i(sel),
    .exc_req_i(exc_req), .exc_code_i(exc_code), .mem_data_i(mem_data),
    .addr_o(a3), .mem_rd_o(rd3), .busy_o(bz3), .vec_target_o(vt3),
    .vec_valid_o(vv3), .exc_drop_o(dr3));

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; exc_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    src_bus  = {32'h0000ABCD, 32'h00002222, 32'h00001000, 32'h00000011};
    sel = 2'd0; exc_code = 2'd0; mem_data = 32'h0;
    do_reset();
    checks++; if (a1 !== 32'h0)   begin errors++; $display("FAIL reset_addr got %h want 0", a1); end
    checks++; if ({rd1, bz1, vv1, dr1} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {rd1, bz1, vv1, dr1}); end
    checks++; if (vt1 !== 32'h0)  begin errors++; $display("FAIL reset_vt got %h want 0", vt1); end
    checks++; if ({a3, rd3, bz3, vv3, dr3} !== 36'h0) begin errors++; $display("FAIL reset_dut3 got %h want 0", {a3, rd3, bz3, vv3, dr3}); end
  endtask

  task automatic test_src_select();
    do_reset();
    sel = 2'd1;
    tick();
    checks++; if (a1 !== 32'h00001000) begin errors++; $display("FAIL sel1_addr got %h want 00001000", a1); end
    sel = 2'd3;
    tick();
    checks++; if (a1 !== 32'h0000ABCD) begin errors++; $display("FAIL sel3_addr got %h want 0000abcd", a1); end
    tick();
    checks++; if (a1 !== 32'h0000ABCD) begin errors++; $display("FAIL sel3_hold got %h want 0000abcd", a1); end
    checks++; if ({rd1, bz1} !== 2'b00) begin errors++; $display("FAIL idle_flags got %b want 00", {rd1, bz1}); end
  endtask

  task automatic test_fetch(input logic [31:0] md, input logic [31:0] exp_vt, input string tag);
    sel = 2'd1;
    exc_req = 1'b1; exc_code = 2'd2;
    tick(); // E0
    exc_req = 1'b0;
    checks++; if (a1 !== 32'd255) begin errors++; $display("FAIL %s_e0_addr got %0d want 255", tag, a1); end
    checks++; if ({rd1, bz1} !== 2'b11) begin errors++; $display("FAIL %s_e0_rdbusy got %b want 11", tag, {rd1, bz1}); end
    tick(); // E1
    checks++; if ({rd1, bz1, vv1} !== 3'b010) begin errors++; $display("FAIL %s_e1_flags got %b want 010", tag, {rd1, bz1, vv1}); end
    checks++; if (a1 !== 32'd255) begin errors++; $display("FAIL %s_e1_addr got %0d want 255", tag, a1); end
    mem_data = md;
    tick(); // E2
    mem_data = 32'h0;
    checks++; if (vt1 !== exp_vt) begin errors++; $display("FAIL %s_vt got %h want %h", tag, vt1, exp_vt); end
    checks++; if ({vv1, bz1} !== 2'b10) begin errors++; $display("FAIL %s_e2_flags got %b want 10", tag, {vv1, bz1}); end
    tick(); // back in IDLE
    checks++; if (vv1 !== 1'b0) begin errors++; $display("FAIL %s_vv_pulse got %b want 0", tag, vv1); end
    checks++; if (vt1 !== exp_vt) begin errors++; $display("FAIL %s_vt_hold got %h want %h", tag, vt1, exp_vt); end
    checks++; if (a1 !== 32'h00001000) begin errors++; $display("FAIL %s_resume got %h want 00001000", tag, a1); end
  endtask

  task automatic test_nested();
    do_reset();
    sel = 2'd2;
    exc_req = 1'b1; exc_code = 2'd0;
    tick(); // E0
    exc_code = 2'd1; // keep requesting while busy
    checks++; if (a1 !== 32'd253) begin errors++; $display("FAIL nest_e0_addr got %0d want 253", a1); end
    tick(); // E1
    checks++; if (dr1 !== 1'b1) begin errors++; $display("FAIL nest_drop1 got %b want 1", dr1); end
    checks++; if (a1 !== 32'd253) begin errors++; $display("FAIL nest_e1_addr got %0d want 253", a1); end
    mem_data = 32'h00000042;
    tick(); // E2
    exc_req = 1'b0;
    checks++; if ({dr1, vv1, bz1} !== 3'b110) begin errors++; $display("FAIL nest_e2_flags got %b want 110", {dr1, vv1, bz1}); end
    checks++; if (vt1 !== 32'h42) begin errors++; $display("FAIL nest_vt got %h want 00000042", vt1); end
    tick();
    checks++; if ({dr1, vv1} !== 2'b00) begin errors++; $display("FAIL nest_after got %b want 00", {dr1, vv1}); end
    checks++; if (a1 !== 32'h00002222) begin errors++; $display("FAIL nest_resume got %h want 00002222", a1); end
  endtask

  task automatic test_invalid_code();
    do_reset();
    sel = 2'd1;
    exc_req = 1'b1; exc_code = 2'd3;
    tick();
    checks++; if ({dr1, bz1, rd1} !== 3'b100) begin errors++; $display("FAIL inv_flags got %b want 100", {dr1, bz1, rd1}); end
    checks++; if (a1 !== 32'h00001000) begin errors++; $display("FAIL inv_addr got %h want 00001000", a1); end
    sel = 2'd2;
    tick(); // back-to-back drop
    checks++; if ({dr1, bz1} !== 2'b10) begin errors++; $display("FAIL inv_b2b got %b want 10", {dr1, bz1}); end
    checks++; if (a1 !== 32'h00002222) begin errors++; $display("FAIL inv_track got %h want 00002222", a1); end
    exc_req = 1'b0;
    tick();
    checks++; if (dr1 !== 1'b0) begin errors++; $display("FAIL inv_clear got %b want 0", dr1); end
  endtask

  task automatic test_long_latency();
    do_reset();
    sel = 2'd0;
    exc_req = 1'b1; exc_code = 2'd1;
    tick(); // E0
    exc_req = 1'b0;
    checks++; if ({a3, rd3, bz3} !== {32'd254, 2'b11}) begin errors++; $display("FAIL ll_e0 got %0d %b%b want 254 11", a3, rd3, bz3); end
    tick(); // E1
    checks++; if ({rd3, bz3} !== 2'b01) begin errors++; $display("FAIL ll_e1 got %b want 01", {rd3, bz3}); end
    tick(); // E2
    mem_data = 32'h0000005A;
    checks++; if ({rd3, bz3, vv3} !== 3'b010) begin errors++; $display("FAIL ll_e2 got %b want 010", {rd3, bz3, vv3}); end
    tick(); // E3
    checks++; if ({vv3, bz3} !== 2'b01) begin errors++; $display("FAIL ll_e3 got %b want 01", {vv3, bz3}); end
    checks++; if (a3 !== 32'd254) begin errors++; $display("FAIL ll_e3_addr got %0d want 254", a3); end
    tick(); // E4
    checks++; if ({vv3, bz3} !== 2'b10) begin errors++; $display("FAIL ll_e4 got %b want 10", {vv3, bz3}); end
    checks++; if (vt3 !== 32'h5A) begin errors++; $display("FAIL ll_vt got %h want 0000005a", vt3); end
    mem_data = 32'h0;
  endtask

  task automatic test_reset_mid();
    // Preload vec_target so the reset clearing it is observable.
    test_long_latency();
    sel = 2'd3;
    exc_req = 1'b1; exc_code = 2'd1;
    tick(); // E0
    exc_req = 1'b0;
    tick(); // E1
    tick(); // E2
    reset = 1'b1; mem_data = 32'h00000077;
    tick(); // E3 under reset
    reset = 1'b0;
    checks++; if ({a3, vt3} !== 64'h0) begin errors++; $display("FAIL rm_data got %h %h want 0 0", a3, vt3); end
    checks++; if ({rd3, bz3, vv3, dr3} !== 4'b0) begin errors++; $display("FAIL rm_flags got %b want 0000", {rd3, bz3, vv3, dr3}); end
    tick();
    checks++; if (vv3 !== 1'b0) begin errors++; $display("FAIL rm_novv1 got %b want 0", vv3); end
    checks++; if (a3 !== 32'h0000ABCD) begin errors++; $display("FAIL rm_track got %h want 0000abcd", a3); end
    tick();
    checks++; if ({vv3, bz3, vt3} !== 34'h0) begin errors++; $display("FAIL rm_novv2 got %b %b %h want 0 0 0", vv3, bz3, vt3); end
    mem_data = 32'h0;
  endtask

  initial begin
    reset = 1'b1; exc_req = 1'b0;
    test_reset();
    test_src_select();
    test_fetch(32'h0000007F, 32'h0000007F, "fetch");
    test_fetch(32'hFFFFFFAB, 32'h000000AB, "zext");
    test_nested();
    test_invalid_code();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
